// File: rtl/trng_ehr_collector_pkg.sv
// Shared widths, EHR geometry and VNC state encoding for the TRNG EHR collector.
// Build option: define TRNG_EHR_192_EN for a 6-word (192-bit) EHR instead of 4 words (128-bit).
package trng_ehr_collector_pkg;

    localparam int SAMPLE_CNT_W = 24;
    localparam int WORD_W       = 32;

`ifdef TRNG_EHR_192_EN
    localparam int EHR_WORDS    = 6;
`else
    localparam int EHR_WORDS    = 4;
`endif

    localparam int EHR_BITS     = WORD_W * EHR_WORDS;
    localparam int BITS_CNT_W   = 8;
    localparam int WORD_SHIFT   = $clog2(WORD_W);
    // Width of the word-index part of bits_cnt
    localparam int PK_W         = BITS_CNT_W - WORD_SHIFT;
    localparam int IDX_W        = 3;

    typedef enum logic {
        VNC_IDLE       = 1'b0,
        VNC_HAVE_FIRST = 1'b1
    } vnc_state_t;

endpackage

// File: rtl/trng_ehr_collector_vnc.sv
// Von Neumann corrector: pairs raw samples, emits the first bit of each unequal pair.
// In bypass every sample is emitted directly and the pairing state is dropped.
module trng_vnc
    import trng_ehr_collector_pkg::*;
(
    input  logic rng_clk,
    input  logic rst,
    input  logic sample_in,
    input  logic sample_vld,
    input  logic bypass,
    input  logic flush,
    output logic bit_out,
    output logic bit_vld
);

    vnc_state_t state_reg, state_next;
    logic       first_reg, first_next;

    always_ff @(posedge rng_clk) begin
        if (rst || flush) begin
            state_reg <= VNC_IDLE;
            first_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            first_reg <= first_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        first_next = first_reg;
        bit_out    = 1'b0;
        bit_vld    = 1'b0;
        if (sample_vld) begin
            if (bypass) begin
                state_next = VNC_IDLE;
                bit_out    = sample_in;
                bit_vld    = 1'b1;
            end else begin
                case (state_reg)
                    VNC_IDLE: begin
                        first_next = sample_in;
                        state_next = VNC_HAVE_FIRST;
                    end
                    VNC_HAVE_FIRST: begin
                        state_next = VNC_IDLE;
                        bit_out    = first_reg;
                        bit_vld    = (first_reg != sample_in);
                    end
                    default: state_next = VNC_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/trng_ehr_collector.sv
// Samples the raw entropy source, runs it through the VNC and packs corrected bits into the EHR.
// EHR size follows TRNG_EHR_192_EN (see trng_ehr_collector_pkg).
module trng_ehr_collector
    import trng_ehr_collector_pkg::*;
(
    input  logic                    rng_clk,
    input  logic                    rst,
    input  logic                    rnd_src_bit,
    input  logic                    rnd_src_en,
    input  logic [SAMPLE_CNT_W-1:0] sample_cnt1,
    input  logic                    vnc_bypass,
    input  logic                    rst_trng_logic,
    input  logic                    prng_trng_ehr_rd,
    input  logic                    cpu_ehr_rd,
    input  logic                    cpu_ehr_wr,
    input  logic [IDX_W-1:0]        cpu_ehr_idx,
    input  logic [WORD_W-1:0]       cpu_wdata,
    output logic                    ehr_valid,
    output logic                    ehr_full,
    output logic [WORD_W-1:0]       ehr_rdata,
    output logic [EHR_BITS-1:0]     ehr_data,
    output logic [BITS_CNT_W-1:0]   bits_cnt
);

    logic [SAMPLE_CNT_W-1:0] samp_cnt_reg;
    logic [BITS_CNT_W-1:0]   bits_cnt_reg;
    logic                    ehr_full_reg;
    logic                    ehr_valid_reg;

    logic flush;
    logic collect_en;
    logic sample_vld;
    logic vnc_bit_out;
    logic vnc_bit_vld;
    logic last_bit;
    logic release_req;
    logic [PK_W-1:0]       pk_word;
    logic [WORD_SHIFT-1:0] pk_bit;

    assign flush       = rst | rst_trng_logic;
    // A full EHR freezes both the sampling counter and the VNC so no bit is dropped
    assign collect_en  = rnd_src_en & ~ehr_full_reg;
    assign sample_vld  = collect_en & (samp_cnt_reg == '0);
    assign last_bit    = vnc_bit_vld & (bits_cnt_reg == BITS_CNT_W'(EHR_BITS - 1));
    assign release_req = prng_trng_ehr_rd
                       | (cpu_ehr_rd & (cpu_ehr_idx == IDX_W'(EHR_WORDS - 1)));
    assign pk_word     = bits_cnt_reg[BITS_CNT_W-1:WORD_SHIFT];
    assign pk_bit      = bits_cnt_reg[WORD_SHIFT-1:0];

    always_ff @(posedge rng_clk) begin
        if (flush) begin
            samp_cnt_reg <= '0;
        end else if (collect_en) begin
            samp_cnt_reg <= (samp_cnt_reg == '0) ? sample_cnt1
                                                 : samp_cnt_reg - SAMPLE_CNT_W'(1);
        end
    end

    trng_vnc u_vnc (
        .rng_clk    (rng_clk),
        .rst        (rst),
        .sample_in  (rnd_src_bit),
        .sample_vld (sample_vld),
        .bypass     (vnc_bypass),
        .flush      (rst_trng_logic),
        .bit_out    (vnc_bit_out),
        .bit_vld    (vnc_bit_vld)
    );

    always_ff @(posedge rng_clk) begin
        if (flush) begin
            bits_cnt_reg  <= '0;
            ehr_full_reg  <= 1'b0;
            ehr_valid_reg <= 1'b0;
        end else begin
            ehr_valid_reg <= last_bit;
            if (vnc_bit_vld) begin
                bits_cnt_reg <= last_bit ? '0 : bits_cnt_reg + BITS_CNT_W'(1);
            end
            if (last_bit) begin
                ehr_full_reg <= 1'b1;
            end else if (ehr_full_reg && release_req) begin
                ehr_full_reg <= 1'b0;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < EHR_WORDS; gi++) begin : g_word
            logic [WORD_W-1:0] word_reg;
            logic              hit_wr;
            logic              hit_bit;

            assign hit_wr  = cpu_ehr_wr & (cpu_ehr_idx == IDX_W'(gi));
            assign hit_bit = vnc_bit_vld & (pk_word == PK_W'(gi));

            // A debug write replaces the whole word, including a packer bit landing this cycle
            always_ff @(posedge rng_clk) begin
                if (flush) begin
                    word_reg <= '0;
                end else if (hit_wr) begin
                    word_reg <= cpu_wdata;
                end else if (hit_bit) begin
                    word_reg[pk_bit] <= vnc_bit_out;
                end
            end

            assign ehr_data[gi*WORD_W +: WORD_W] = word_reg;
        end
    endgenerate

    always_comb begin
        ehr_rdata = '0;
        for (int i = 0; i < EHR_WORDS; i++) begin
            if (cpu_ehr_idx == IDX_W'(i)) begin
                ehr_rdata = ehr_data[i*WORD_W +: WORD_W];
            end
        end
    end

    assign ehr_valid = ehr_valid_reg;
    assign ehr_full  = ehr_full_reg;
    assign bits_cnt  = bits_cnt_reg;

endmodule

// File: tb/tb_trng_ehr_collector.sv
// Randomised bench for trng_ehr_collector: sample-stream reference model plus an ehr_valid scoreboard.
module tb_trng_ehr_collector;
    import trng_ehr_collector_pkg::*;

    logic                    rng_clk = 1'b0;
    logic                    rst;
    logic                    rnd_src_bit;
    logic                    rnd_src_en;
    logic [SAMPLE_CNT_W-1:0] sample_cnt1;
    logic                    vnc_bypass;
    logic                    rst_trng_logic;
    logic                    prng_trng_ehr_rd;
    logic                    cpu_ehr_rd;
    logic                    cpu_ehr_wr;
    logic [IDX_W-1:0]        cpu_ehr_idx;
    logic [WORD_W-1:0]       cpu_wdata;
    logic                    ehr_valid;
    logic                    ehr_full;
    logic [WORD_W-1:0]       ehr_rdata;
    logic [EHR_BITS-1:0]     ehr_data;
    logic [BITS_CNT_W-1:0]   bits_cnt;

    always #5 rng_clk = ~rng_clk;

    trng_ehr_collector dut (
        .rng_clk          (rng_clk),
        .rst              (rst),
        .rnd_src_bit      (rnd_src_bit),
        .rnd_src_en       (rnd_src_en),
        .sample_cnt1      (sample_cnt1),
        .vnc_bypass       (vnc_bypass),
        .rst_trng_logic   (rst_trng_logic),
        .prng_trng_ehr_rd (prng_trng_ehr_rd),
        .cpu_ehr_rd       (cpu_ehr_rd),
        .cpu_ehr_wr       (cpu_ehr_wr),
        .cpu_ehr_idx      (cpu_ehr_idx),
        .cpu_wdata        (cpu_wdata),
        .ehr_valid        (ehr_valid),
        .ehr_full         (ehr_full),
        .ehr_rdata        (ehr_rdata),
        .ehr_data         (ehr_data),
        .bits_cnt         (bits_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Scoreboard: expected EHR contents at each ehr_valid pulse
    logic [EHR_BITS-1:0] exp_q[$];

    // Reference model state
    logic [EHR_BITS-1:0] m_ehr;
    int                  m_bcnt;
    bit                  m_full;
    bit                  m_valid;
    int                  m_wait;
    bit                  m_pend_q[$];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_ehr  = '0;
        m_bcnt = 0;
        m_full = 1'b0;
        m_wait = 0;
        m_pend_q.delete();
    endfunction

    // Applies the spec rules for one clock edge using the inputs currently driven
    function automatic void model_edge();
        bit was_full;
        bit emit;
        bit ebit;
        bit first;
        m_valid  = 1'b0;
        if (rst || rst_trng_logic) begin
            model_reset();
            return;
        end
        was_full = m_full;
        emit     = 1'b0;
        ebit     = 1'b0;
        if (rnd_src_en && !m_full) begin
            if (m_wait == 0) begin
                m_wait = int'(sample_cnt1);
                if (vnc_bypass) begin
                    m_pend_q.delete();
                    emit = 1'b1;
                    ebit = rnd_src_bit;
                end else if (m_pend_q.size() == 0) begin
                    m_pend_q.push_back(rnd_src_bit);
                end else begin
                    first = m_pend_q.pop_front();
                    if (first != rnd_src_bit) begin
                        emit = 1'b1;
                        ebit = first;
                    end
                end
            end else begin
                m_wait--;
            end
        end
        if (emit) begin
            m_ehr[m_bcnt] = ebit;
            m_bcnt++;
        end
        if (cpu_ehr_wr && cpu_ehr_idx < EHR_WORDS)
            m_ehr[cpu_ehr_idx*WORD_W +: WORD_W] = cpu_wdata;
        if (m_bcnt == EHR_BITS) begin
            m_bcnt  = 0;
            m_full  = 1'b1;
            m_valid = 1'b1;
            exp_q.push_back(m_ehr);
        end else if (was_full && (prng_trng_ehr_rd ||
                   (cpu_ehr_rd && cpu_ehr_idx == EHR_WORDS - 1))) begin
            m_full = 1'b0;
        end
    endfunction

    task automatic step();
        model_edge();
        @(posedge rng_clk);
        #1;
        rst_trng_logic   = 1'b0;
        prng_trng_ehr_rd = 1'b0;
        cpu_ehr_rd       = 1'b0;
        cpu_ehr_wr       = 1'b0;
        check("bits_cnt", bits_cnt, m_bcnt);
        check("ehr_full", ehr_full, m_full);
        check("ehr_valid", ehr_valid, m_valid);
        check("ehr_data", ehr_data, m_ehr);
    endtask

    task automatic check_rdata(input int idx);
        logic [WORD_W-1:0] exp;
        cpu_ehr_idx = IDX_W'(idx);
        #1;
        exp = (idx < EHR_WORDS) ? m_ehr[idx*WORD_W +: WORD_W] : '0;
        check($sformatf("ehr_rdata[%0d]", idx), ehr_rdata, exp);
    endtask

    task automatic run_until_full(input string name, input int budget);
        int cyc = 0;
        while (!m_full && cyc < budget) begin
            rnd_src_bit = 1'($urandom);
            step();
            cyc++;
        end
        checks++;
        if (!m_full) begin
            errors++;
            $display("FAIL %s: timeout after %0d cycles, EHR not full", name, cyc);
        end
    endtask

    // Monitor: every ehr_valid pulse must match the next expected block
    initial begin
        logic [EHR_BITS-1:0] exp;
        forever begin
            @(negedge rng_clk);
            if (ehr_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_valid: unexpected ehr_valid pulse (t=%0t)", $time);
                end else begin
                    exp = exp_q.pop_front();
                    if (ehr_data !== exp) begin
                        errors++;
                        $display("FAIL sb_block: got %0h expected %0h", ehr_data, exp);
                    end else begin
                        $display("block ok: ehr_data=%0h", ehr_data);
                    end
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq[8] = '{0, 1, 1, 0, 0, 0, 1, 1};
        logic [EHR_BITS-1:0] ones;
        ones             = '1;
        rst              = 1'b1;
        rnd_src_bit      = 1'b0;
        rnd_src_en       = 1'b0;
        sample_cnt1      = '0;
        vnc_bypass       = 1'b0;
        rst_trng_logic   = 1'b0;
        prng_trng_ehr_rd = 1'b0;
        cpu_ehr_rd       = 1'b0;
        cpu_ehr_wr       = 1'b0;
        cpu_ehr_idx      = '0;
        cpu_wdata        = '0;
        model_reset();
        repeat (3) step();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) check_rdata(i);
        check("reset_bits_cnt", bits_cnt, 0);

        // Bypass, constant 1, one sample every 4 cycles
        sample_cnt1 = 3;
        vnc_bypass  = 1'b1;
        rnd_src_en  = 1'b1;
        begin
            int cyc = 0;
            rnd_src_bit = 1'b1;
            while (!m_full && cyc < 2000) begin
                step();
                cyc++;
            end
            check("t1_full", ehr_full, 1);
            check("t1_all_ones", ehr_data, ones);
        end
        prng_trng_ehr_rd = 1'b1;
        step();
        check("t1_release", ehr_full, 0);

        // VNC pairs 01,10,00,11 -> bits 0,1
        rst_trng_logic = 1'b1;
        step();
        sample_cnt1 = 0;
        vnc_bypass  = 1'b0;
        foreach (seq[i]) begin
            rnd_src_bit = 1'(seq[i]);
            step();
        end
        check("t2_bits_cnt", bits_cnt, 2);
        check("t2_bits", ehr_data[1:0], 2'b10);

        // Random fill, stall while full, release via last-word CPU read
        sample_cnt1 = SAMPLE_CNT_W'($urandom_range(0, 2));
        run_until_full("t3_fill", 20000);
        for (int i = 0; i < 20; i++) begin
            rnd_src_bit = 1'(i & 1);
            step();
        end
        check("t3_stall_cnt", bits_cnt, 0);
        for (int i = 0; i < EHR_WORDS; i++) begin
            cpu_ehr_idx = IDX_W'(i);
            cpu_ehr_rd  = 1'b1;
            step();
            check($sformatf("t3_full_after_rd%0d", i), ehr_full, (i != EHR_WORDS - 1));
        end
        repeat (4) step();

        // Flush at bits_cnt=77 with the VNC holding a first sample of 0
        rst_trng_logic = 1'b1;
        step();
        sample_cnt1 = 0;
        vnc_bypass  = 1'b1;
        for (int i = 0; i < 77; i++) begin
            rnd_src_bit = 1'($urandom);
            step();
        end
        vnc_bypass  = 1'b0;
        rnd_src_bit = 1'b0;
        step();
        check("t4_pre_cnt", bits_cnt, 77);
        rst_trng_logic = 1'b1;
        step();
        check("t4_cnt_zero", bits_cnt, 0);
        check("t4_ehr_zero", ehr_data, 0);
        rnd_src_bit = 1'b1;
        step();
        rnd_src_bit = 1'b0;
        step();
        check("t4_vnc_idle", ehr_data[7:0], 8'h01);

        // Debug writes with collection disabled
        rnd_src_en  = 1'b0;
        cpu_ehr_wr  = 1'b1;
        cpu_ehr_idx = 3'd2;
        cpu_wdata   = 32'hDEAD_BEEF;
        step();
        check_rdata(2);
        check("t5_word2", ehr_rdata, 32'hDEAD_BEEF);
        check("t5_full", ehr_full, 0);
        check("t5_valid", ehr_valid, 0);
        cpu_ehr_wr  = 1'b1;
        cpu_ehr_idx = 3'd7;
        cpu_wdata   = $urandom;
        step();
        for (int i = 0; i < 8; i++) check_rdata(i);
        check("t5_oob_read", ehr_rdata, 0);

        // Bypass at full rate, PRNG release
        rst_trng_logic = 1'b1;
        step();
        rnd_src_en = 1'b1;
        vnc_bypass = 1'b1;
        run_until_full("t6_fill", EHR_BITS + 4);
        prng_trng_ehr_rd = 1'b1;
        step();
        check("t6_release", ehr_full, 0);
        rnd_src_bit = 1'b1;
        step();
        check("t6_resume", bits_cnt, 1);

        // Random soak
        for (int i = 0; i < 4000; i++) begin
            rnd_src_bit = 1'($urandom);
            rnd_src_en  = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 99) == 0) sample_cnt1 = SAMPLE_CNT_W'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) vnc_bypass = 1'($urandom);
            prng_trng_ehr_rd = ($urandom_range(0, 39) == 0);
            cpu_ehr_idx      = IDX_W'($urandom_range(0, 7));
            cpu_ehr_rd       = ($urandom_range(0, 9) == 0);
            cpu_ehr_wr       = ($urandom_range(0, 49) == 0);
            cpu_wdata        = $urandom;
            rst_trng_logic   = ($urandom_range(0, 999) == 0);
            step();
            if (i % 16 == 0) check_rdata($urandom_range(0, 7));
        end

        repeat (3) @(posedge rng_clk);
        #1;
        check("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
